// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN calculator stack datapath (push and pop sides).
// Pure declarations; no timing of its own.
// Not applicable: holds no flow-controlled logic.
package rpn_pkg;

  // The push FSM uses 4'h0-4'h3. The pop FSM starts at 4'h8 so a state
  // probe on a shared debug bus can tell the two machines apart.
  localparam logic [3:0] PUSH_IDLE  = 4'h0;
  localparam logic [3:0] PUSH_WRITE = 4'h1;
  localparam logic [3:0] PUSH_INC   = 4'h2;
  localparam logic [3:0] PUSH_DONE  = 4'h3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'h8,
    ST_ADDR = 4'h9,
    ST_WAIT = 4'hA,
    ST_CAPT = 4'hB,
    ST_DONE = 4'hC
  } pop_state_t;

  typedef enum logic {
    OP_POP  = 1'b0,
    OP_PEEK = 1'b1
  } pop_op_t;

  // Active-low segment patterns {g,f,e,d,c,b,a} for the "Err" message.
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/rpn_reg_en.sv
// Load-enable register with synchronous active-low reset.
// Latency: 1 cycle from i_en to o_q.
// No backpressure; the value holds until the next enabled load.
module rpn_reg_en #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Capture i_d when enabled; reset clears the stored value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/rpn_underflow_flag.sv
// Sticky underflow error flag feeding the "Err" display path.
// Latency: 1 cycle from set/clear to o_flag.
// No backpressure; set wins over a coincident clear.
module rpn_underflow_flag (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_flag
);

  logic r_flag;

  // Set has priority so a fresh underflow is never lost to a clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    r_flag <= 1'b0;
    else if (i_set)  r_flag <= 1'b1;
    else if (i_clr)  r_flag <= 1'b0;
  end

  assign o_flag = r_flag;

endmodule

// File: rtl/rpn_stack_pop.sv
// Read-side stack controller: pop (SP-1 and read) or peek (read only) of the top entry.
// Latency: request to data_valid is RAM_LAT+2 cycles.
// Requests while busy are dropped; the push side must hold off while busy=1.
module rpn_stack_pop
  import rpn_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              pop_req,
  input  logic              peek_req,
  input  logic              err_clr,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_load,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              underflow
);

  pop_state_t        r_state;
  pop_state_t        w_state_nxt;
  pop_op_t           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              w_idle;
  logic              w_req;
  logic              w_sp_zero;
  logic              w_accept;
  logic              w_uflow_set;
  logic              w_capt;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_req       = pop_req | peek_req;
  assign w_sp_zero   = (sp_in == '0);
  assign w_accept    = w_idle & w_req & ~w_sp_zero;
  assign w_uflow_set = w_idle & w_req & w_sp_zero;
  assign w_capt      = (r_state == ST_CAPT);

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; the WAIT state is only visited for a 2-cycle RAM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_ADDR;
      ST_ADDR: w_state_nxt = (RAM_LAT == 2) ? ST_WAIT : ST_CAPT;
      ST_WAIT: w_state_nxt = ST_CAPT;
      ST_CAPT: w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the operation and the top-of-stack address when a request is taken;
  // sp_in is ignored for the rest of the transaction.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_op   <= OP_POP;
      r_addr <= '0;
    end else if (w_accept) begin
      r_op   <= pop_req ? OP_POP : OP_PEEK;
      r_addr <= sp_in - ADDR_W'(1);
    end
  end

  // The latched address doubles as the new SP, so a pop needs no extra adder.
  assign ram_addr   = r_addr;
  assign sp_out     = r_addr;
  // Gated by reset_n so a reset landing in CAPT cannot commit the SP change.
  assign sp_load    = w_capt & (r_op == OP_POP) & reset_n;
  assign busy       = ~w_idle;
  assign data_valid = (r_state == ST_DONE);

  rpn_reg_en #(
    .W(DATA_W)
  ) u_data_reg (
    .i_clk   (CLOCK_50),
    .i_rst_n (reset_n),
    .i_en    (w_capt),
    .i_d     (ram_rdata),
    .o_q     (data_out)
  );

  rpn_underflow_flag u_uflow (
    .i_clk   (CLOCK_50),
    .i_rst_n (reset_n),
    .i_set   (w_uflow_set),
    .i_clr   (err_clr),
    .o_flag  (underflow)
  );

endmodule

// File: doc/rpn_stack_pop.md
Name: rpn_stack_pop

Overview:
- Read-side controller for the RPN calculator's stack RAM; the counterpart of the push datapath that writes RAM[SP] and then increments SP.
- On a pop request it decrements the stack pointer, reads the top-of-stack word from the synchronous-read RAM, and presents it with a one-cycle valid strobe.
- Also supports a non-destructive peek.
- Detects underflow and latches an error flag that drives the "Err" display path.

Parameters:
- DATA_W, 8, width of stack entries.
- ADDR_W, 8, width of the stack pointer and RAM address.
- RAM_LAT, 1, RAM read latency in cycles (address to data), 1 or 2.

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous active-low reset, sampled on the CLOCK_50 posedge.
- pop_req  in  1  request a pop; level, sampled only in IDLE.
- peek_req  in  1  request a read of the top entry without changing SP; sampled only in IDLE; pop_req has priority.
- err_clr  in  1  clears the latched underflow flag.
- sp_in  in  ADDR_W  current stack pointer (next free slot; 0 = empty).
- ram_rdata  in  DATA_W  RAM read data.
- ram_addr  out  ADDR_W  RAM read address.
- sp_out  out  ADDR_W  new SP value.
- sp_load  out  1  one-cycle SP register load enable.
- busy  out  1  high whenever not IDLE; the push FSM must not start while busy=1.
- data_out  out  DATA_W  popped or peeked word, held until the next completion.
- data_valid  out  1  one-cycle strobe when data_out updates.
- underflow  out  1  latched error flag.

Behaviour:
- Reset (reset_n=0 at an edge) forces these values; a reset mid-operation aborts with no SP load:
  - state=IDLE
  - data_out=0, data_valid=0, sp_load=0, underflow=0, busy=0
  - ram_addr=0, sp_out=0
- States: IDLE, ADDR, WAIT, CAPT, DONE.
- IDLE:
  - pop_req=1 or peek_req=1 with sp_in==0: no RAM access; underflow<=1; stay IDLE; data_out unchanged; no data_valid.
  - pop_req=1 and sp_in!=0: latch op=POP and addr=sp_in-1; go to ADDR.
  - peek_req=1 (pop_req=0) and sp_in!=0: latch op=PEEK and addr=sp_in-1; go to ADDR.
- ADDR: ram_addr=latched addr. Go to WAIT if RAM_LAT=2, otherwise to CAPT.
- WAIT: hold ram_addr; go to CAPT.
- CAPT:
  - data_out<=ram_rdata.
  - If op=POP: sp_out=latched addr, sp_load=1 for exactly this cycle.
  - Go to DONE.
- DONE: data_valid=1 for this cycle only; go to IDLE.
- Latency: request in IDLE to data_valid is 3 cycles for RAM_LAT=1 and 4 for RAM_LAT=2. Back-to-back pops therefore have 4 or 5 cycle spacing.
- Requests arriving while busy are ignored, not queued. A level-held pop_req re-triggers on the next IDLE; the key edge detector upstream must supply single pulses.
- ram_addr holds the latched address from ADDR through CAPT; its value in IDLE and DONE is don't-care.
- SP arithmetic is modulo 2^ADDR_W. No wrap-around occurs because sp_in==0 is rejected before the subtraction.
- Underflow flag:
  - Sticky; cleared only by err_clr=1 in any state, or by reset.
  - If err_clr and a new underflow coincide in the same cycle, set wins.
  - Underflow does not block later valid pops.
- sp_in is sampled only in IDLE; changes during a transaction are ignored.

Decomposition:
- Shared package rpn_pkg holds:
  - state encodings (4-bit, alongside the push FSM's encodings, with no value overlap)
  - op encodings POP/PEEK
  - the 7-segment constants used for the "Err" display
- One natural sub-module: rpn_underflow_flag (sticky set/clear register, set-priority).
- The FSM and datapath stay in rpn_stack_pop.
- Reuse the existing 8-bit load-enable register for data_out.

Test Plan:
- Reset then pop with sp_in=0 -> no sp_load, no data_valid, underflow=1; then err_clr=1 -> underflow=0.
- RAM[2]=0x5A, sp_in=3, pop_req for 1 cycle (RAM_LAT=1):
  - ram_addr=2 in ADDR
  - sp_load=1 with sp_out=2 in CAPT, 2 cycles after the request
  - data_valid=1 with data_out=0x5A in DONE, 3 cycles after the request
- RAM[0]=0x11, sp_in=1, peek_req -> data_out=0x11, data_valid pulses, sp_load never asserts.
- pop_req and peek_req together, sp_in=4, RAM[3]=0xC3 -> treated as pop: sp_out=3, data_out=0xC3.
- Pop in progress, reset_n=0 asserted in the CAPT cycle -> no data_valid, state IDLE, data_out=0, busy=0 next cycle.
- RAM_LAT=2, sp_in=0x80, RAM[0x7F]=0xFF -> data_valid 4 cycles after the request, sp_out=0x7F; a second pop_req while busy is ignored.
